max_pooling_layer_26x26: RTL and testbench

- 2x2, stride-2 max-pooling stage of the CNN accelerator.
- Reads a 26x26 signed 16-bit feature map from an external synchronous-read RAM and writes a 13x13 pooled map to an external RAM.
- Sits between a convolution/activation layer's output buffer and the next layer's input buffer.
- Controlled by a start pulse and reports completion through done.

---
 rtl/max_pooling_layer_26x26.sv | 104 ++++++++++
 tb/tb_max_pooling_layer_26x26.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/max_pooling_layer_26x26.sv
// max_pooling_layer_26x26: 2x2 stride-2 signed max-pooling of a 26x26 map from sync-read RAM into a 13x13 map
module max_pooling_layer_26x26 #(
    parameter int DATA_W = 16,
    parameter int IN_DIM = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [9:0]        in_map_addr,
    input  logic [DATA_W-1:0] in_map_pixel,
    output logic [7:0]        out_map_addr,
    output logic [DATA_W-1:0] out_map_pixel,
    output logic              out_map_write_en,
    output logic              done
);
    localparam int OUT_DIM = IN_DIM / 2;

    typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, ISSUE2, ISSUE3, LAST, WRITE, DONE} state_t;

    state_t                   state, state_nxt;
    logic [3:0]               r, c;
    logic signed [DATA_W-1:0] acc, max_v;
    logic                     row_end, map_end;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state: four reads per window, one write cycle, then advance or finish
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? ISSUE0 : state;
            ISSUE0:     state_nxt = ISSUE1;
            ISSUE1:     state_nxt = ISSUE2;
            ISSUE2:     state_nxt = ISSUE3;
            ISSUE3:     state_nxt = LAST;
            LAST:       state_nxt = WRITE;
            WRITE:      state_nxt = map_end ? DONE : ISSUE0;
            default:    state_nxt = IDLE;
        endcase
    end

    // running signed maximum and window position decode
    always_comb begin
        max_v   = ($signed(in_map_pixel) > acc) ? $signed(in_map_pixel) : acc;
        row_end = c == 4'(OUT_DIM - 1);
        map_end = row_end && (r == 4'(OUT_DIM - 1));
    end

    // datapath: addresses run one cycle ahead of the RAM data they fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r                <= '0;
            c                <= '0;
            acc              <= '0;
            in_map_addr      <= '0;
            out_map_addr     <= '0;
            out_map_pixel    <= '0;
            out_map_write_en <= 1'b0;
            done             <= 1'b0;
        end else begin
            out_map_write_en <= state == LAST;
            case (state)
                IDLE, DONE: if (start) begin
                    r           <= '0;
                    c           <= '0;
                    in_map_addr <= '0;
                    done        <= 1'b0;
                end
                ISSUE0: in_map_addr <= in_map_addr + 10'd1;
                ISSUE1: begin
                    acc         <= $signed(in_map_pixel);
                    in_map_addr <= in_map_addr + 10'(IN_DIM - 1);
                end
                ISSUE2: begin
                    acc         <= max_v;
                    in_map_addr <= in_map_addr + 10'd1;
                end
                ISSUE3: acc <= max_v;
                LAST: begin
                    acc           <= max_v;
                    out_map_pixel <= max_v;
                    out_map_addr  <= 8'(r) * 8'(OUT_DIM) + 8'(c);
                end
                WRITE: begin
                    // address sits at base+IN_DIM+1 here: +1 reaches the next row pair, -(IN_DIM-1) the next column pair
                    if (map_end) done <= 1'b1;
                    else if (row_end) begin
                        c           <= '0;
                        r           <= r + 4'd1;
                        in_map_addr <= in_map_addr + 10'd1;
                    end else begin
                        c           <= c + 4'd1;
                        in_map_addr <= in_map_addr - 10'(IN_DIM - 1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_max_pooling_layer_26x26.sv
// tb_max_pooling_layer_26x26: scoreboard bench for the 2x2 max-pooling layer
module tb_max_pooling_layer_26x26;
    typedef struct {int addr; int pix;} exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  in_map_addr;
    logic [15:0] in_map_pixel = '0;
    logic [7:0]  out_map_addr;
    logic [15:0] out_map_pixel;
    logic        out_map_write_en;
    logic        done;

    int   mem [676];
    int   out_mem [169];
    exp_t q[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, start_cyc = 0, last_wr = 0;
    int   wr_total = 0, wr_base = 0;
    bit   chk_done_next = 1'b0;

    max_pooling_layer_26x26 dut (
        .clk(clk), .reset(reset), .start(start),
        .in_map_addr(in_map_addr), .in_map_pixel(in_map_pixel),
        .out_map_addr(out_map_addr), .out_map_pixel(out_map_pixel),
        .out_map_write_en(out_map_write_en), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read input RAM, one cycle latency
    always @(posedge clk) in_map_pixel <= 16'(mem[in_map_addr]);

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int win_max(int k);
        int b, m;
        b = 52 * (k / 13) + 2 * (k % 13);
        m = mem[b];
        if (mem[b + 1] > m) m = mem[b + 1];
        if (mem[b + 26] > m) m = mem[b + 26];
        if (mem[b + 27] > m) m = mem[b + 27];
        return m;
    endfunction

    // write monitor: scoreboard pop, spacing and done-rise checks
    always @(negedge clk) begin
        exp_t e;
        if (chk_done_next) begin
            check("done_rise", int'(done), 1);
            chk_done_next = 1'b0;
        end
        if (reset && out_map_write_en) begin
            if (q.size() == 0) check("spurious_wr", int'(out_map_addr), -1);
            else begin
                e = q.pop_front();
                check("wr_addr", int'(out_map_addr), e.addr);
                check("wr_pix", int'($signed(out_map_pixel)), e.pix);
            end
            if (wr_total == wr_base) check("first_lat", cyc - start_cyc, 5);
            else check("wr_gap", cyc - last_wr, 6);
            check("done_during_wr", int'(done), 0);
            last_wr = cyc;
            out_mem[out_map_addr] = int'($signed(out_map_pixel));
            wr_total++;
            if (wr_total - wr_base == 169) chk_done_next = 1'b1;
        end
    end

    task automatic pulse_start(bit fresh);
        @(negedge clk);
        start = 1'b1;
        if (fresh) begin
            wr_base = wr_total;
            for (int k = 0; k < 169; k++) q.push_back('{k, win_max(k)});
        end
        @(posedge clk);
        #1;
        if (fresh) begin
            start_cyc = cyc;
            check("done_clr", int'(done), 0);
        end
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 1200 && !done; i++) @(negedge clk);
        check("done_to", int'(done), 1);
        check("n_writes", wr_total - wr_base, 169);
        check("sb_empty", q.size(), 0);
        repeat (3) @(negedge clk);
        check("done_hold", int'(done), 1);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_in_addr"}, int'(in_map_addr), 0);
        check({tag, "_out_addr"}, int'(out_map_addr), 0);
        check({tag, "_out_pix"}, int'(out_map_pixel), 0);
        check({tag, "_we"}, int'(out_map_write_en), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        for (int i = 0; i < 676; i++) mem[i] = i % 50;
        mem[0] = 10; mem[1] = 20; mem[26] = 30; mem[27] = 100;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // pass 1 with ignored start pulses while busy
        pulse_start(1'b1);
        repeat (40) @(negedge clk);
        pulse_start(1'b0);
        repeat (300) @(negedge clk);
        pulse_start(1'b0);
        wait_done();
        check("out0", out_mem[0], 100);
        check("out1", out_mem[1], 29);
        check("out2", out_mem[2], 31);

        // restart from DONE reproduces the same map
        out_mem[0] = 0;
        pulse_start(1'b1);
        wait_done();
        check("out0_again", out_mem[0], 100);

        // random data with signed corner windows at outputs 5, 6, 7
        for (int i = 0; i < 676; i++) mem[i] = int'($signed(16'($urandom)));
        mem[10] = -5;     mem[11] = -300;  mem[36] = -2; mem[37] = -32768;
        mem[12] = 7;      mem[13] = 7;     mem[38] = 7;  mem[39] = 7;
        mem[14] = -32768; mem[15] = 32767; mem[40] = 0;  mem[41] = 1;
        pulse_start(1'b1);
        wait_done();
        check("neg_win", out_mem[5], -2);
        check("eq_win", out_mem[6], 7);
        check("ext_win", out_mem[7], 32767);

        // asynchronous abort after 50 writes
        pulse_start(1'b1);
        for (int i = 0; i < 1200 && (wr_total - wr_base) < 50; i++) begin
            @(posedge clk);
            #2;
        end
        check("abort_reach", wr_total - wr_base, 50);
        #1 reset = 1'b0;
        #1 check_reset_outputs("abort");
        q.delete();
        repeat (5) @(negedge clk);
        check("abort_no_wr", wr_total - wr_base, 50);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_done", int'(done), 0);
        check("idle_we", int'(out_map_write_en), 0);
        pulse_start(1'b1);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
